cache_mem_arbiter: RTL

Shares the single line-wide main-memory port between the instruction cache and the data cache. Both caches issue line-fill reads; the data cache also issues line write-backs. The block arbitrates round-robin on conflicts and sequences one fixed-latency memory transaction at a time. It returns the 64-bit line to the owning cache with a one-cycle done pulse. It sits between the two cache controllers and the memory model.

---
 rtl/cache_mem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter that shares one line-wide memory port between the I-cache and D-cache.
// One transaction is in flight at a time, with fixed latency and a one-cycle done pulse to the owner.
module cache_mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int LINE_SIZE   = 64,
  parameter int MEM_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_grant,
  output logic                 i_done,
  output logic [LINE_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [LINE_SIZE-1:0] d_wdata,
  output logic                 d_grant,
  output logic                 d_done,
  output logic [LINE_SIZE-1:0] d_rdata,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [LINE_SIZE-1:0] mem_wdata,
  input  logic [LINE_SIZE-1:0] mem_rdata,
  output logic [15:0]          conflict_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0]           CNT_LAST  = 4'(MEM_LATENCY - 1);
  localparam logic [WORD_SIZE-1:0] LINE_MASK = ~(WORD_SIZE'(3));

  state_t               state_reg, state_next;
  logic [3:0]           cnt_reg;
  logic                 last_owner_reg;
  logic                 owner_reg;
  logic                 we_reg;
  logic [WORD_SIZE-1:0] addr_reg;
  logic [LINE_SIZE-1:0] wdata_reg;
  logic [LINE_SIZE-1:0] i_rdata_reg, d_rdata_reg;
  logic [15:0]          conflict_cnt_reg;

  logic grant_valid;
  logic grant_d;
  logic busy_last;

  // On a tie the D-cache wins only when the I-cache was served last.
  assign grant_valid = i_req | d_req;
  assign grant_d     = d_req & (~i_req | ~last_owner_reg);
  assign busy_last   = (state_reg == BUSY) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = BUSY;
      BUSY:    if (busy_last)   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_reg          <= '0;
      last_owner_reg   <= 1'b1;
      owner_reg        <= 1'b0;
      we_reg           <= 1'b0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      i_rdata_reg      <= '0;
      d_rdata_reg      <= '0;
      conflict_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (i_req && d_req) conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
          if (grant_valid) begin
            owner_reg <= grant_d;
            we_reg    <= grant_d & d_we;
            addr_reg  <= (grant_d ? d_addr : i_addr) & LINE_MASK;
            if (grant_d) wdata_reg <= d_wdata;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + 4'd1;
          if (busy_last && !we_reg) begin
            if (owner_reg) d_rdata_reg <= mem_rdata;
            else           i_rdata_reg <= mem_rdata;
          end
        end
        DONE: last_owner_reg <= owner_reg;
        default: ;
      endcase
    end
  end

  always_comb begin
    i_grant   = 1'b0;
    d_grant   = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_reg)
      BUSY: begin
        i_grant   = ~owner_reg;
        d_grant   = owner_reg;
        mem_read  = ~we_reg;
        mem_write = we_reg;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
      end
      DONE: begin
        i_grant   = ~owner_reg;
        d_grant   = owner_reg;
        i_done    = ~owner_reg;
        d_done    = owner_reg;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
      end
      default: ;
    endcase
  end

  assign i_rdata      = i_rdata_reg;
  assign d_rdata      = d_rdata_reg;
  assign conflict_cnt = conflict_cnt_reg;

endmodule
